sram_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single external 16-bit SRAM between the master SLC-3 (requester 0) and slave SLC-3 cores (requesters 1..NUM_REQ-1).
- Latches one request, drives the SRAM control, address and write-data pins through a fixed-timing access, and returns read data plus a one-cycle done pulse to the served requester.
- Sits between the CPU memory ports and the board-level SRAM tristate buffer.

---
 rtl/sram_rr_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin arbiter and sequencer for a shared external 16-bit SRAM
//
// Purpose: serves one of NUM_REQ memory ports at a time (requester 0 is the
// master CPU). Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE.
// The served requester receives read data and a one-cycle req_done pulse.
// Every output is registered.
//
// Optional feature: define MSTR_PRIORITY_EN to give requester 0 absolute
// priority. The other requesters then share round-robin among themselves.
//
// Ports:
//   Clk, Reset           clock (rising edge), synchronous active-low reset
//   read_req, write_req  level requests, one bit per requester
//   addr_in, wdata_in    flattened per-requester address / write data
//   grant, req_done      one-hot served requester / completion pulse
//   rdata_out            last read data, held until the next read completes
//   busy                 high whenever the sequencer is not in IDLE
//   sram_*               SRAM address, data, tristate enable and strobes

module sram_rr_arbiter #(
    parameter int NUM_REQ       = 5,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         read_req,
    input  logic [NUM_REQ-1:0]         write_req,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_in,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [DATA_W-1:0]          rdata_out,
    output logic                       busy,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [DATA_W-1:0]          sram_wdata,
    output logic                       sram_wdata_oe,
    input  logic [DATA_W-1:0]          sram_rdata,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              state, state_d;
    logic [IW-1:0]       ptr, ptr_d;
    logic [IW-1:0]       win, win_d;
    logic                op_wr, op_wr_d;
    logic [CW-1:0]       cnt, cnt_d;

    logic [NUM_REQ-1:0]  grant_d, req_done_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                busy_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                wdata_oe_d, ce_n_d, oe_n_d, we_n_d;

    logic [NUM_REQ-1:0]  pending;
    logic                arb_found;
    logic [IW-1:0]       arb_idx;
    logic [IW-1:0]       win_next;

    // Pick the first pending requester at or above the pointer, wrapping.
    always_comb begin
        pending   = read_req | write_req;
        arb_found = 1'b0;
        arb_idx   = '0;
`ifdef MSTR_PRIORITY_EN
        if (pending[0]) begin
            arb_found = 1'b1;
        end
`endif
        for (int off = 0; off < NUM_REQ; off++) begin : scan
            int cand;
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
`ifdef MSTR_PRIORITY_EN
            if (!arb_found && cand != 0 && pending[cand]) begin
`else
            if (!arb_found && pending[cand]) begin
`endif
                arb_found = 1'b1;
                arb_idx   = IW'(cand);
            end
        end
    end

    assign win_next = (win == IDX_LAST) ? '0 : win + 1'b1;

    // Next-state and next-output logic. Because outputs are registered, each
    // transition loads the pin values that the destination state presents.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        win_d      = win;
        op_wr_d    = op_wr;
        cnt_d      = cnt;
        grant_d    = grant;
        req_done_d = '0;
        rdata_d    = rdata_out;
        busy_d     = busy;
        addr_d     = sram_addr;
        wdata_d    = sram_wdata;
        wdata_oe_d = sram_wdata_oe;
        ce_n_d     = sram_ce_n;
        oe_n_d     = sram_oe_n;
        we_n_d     = sram_we_n;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_d = SETUP;
                    win_d   = arb_idx;
                    // A write takes precedence over a read from the same port.
                    op_wr_d = write_req[arb_idx];
                    grant_d = NUM_REQ'(1) << arb_idx;
                    busy_d  = 1'b1;
                    ce_n_d  = 1'b0;
                    addr_d  = addr_in[int'(arb_idx)*ADDR_W +: ADDR_W];
                    if (write_req[arb_idx]) begin
                        wdata_d    = wdata_in[int'(arb_idx)*DATA_W +: DATA_W];
                        wdata_oe_d = 1'b1;
                    end else begin
                        oe_n_d = 1'b0;
                    end
                end
            end
            SETUP: begin
                // The write strobe holds off for one cycle to give address setup.
                state_d = ACCESS;
                cnt_d   = '0;
                if (op_wr) begin
                    we_n_d = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    state_d    = DONE;
                    ce_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    we_n_d     = 1'b1;
                    wdata_oe_d = 1'b0;
                    req_done_d = NUM_REQ'(1) << win;
                    if (!op_wr) begin
                        rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
`ifdef MSTR_PRIORITY_EN
                if (win != '0) begin
                    ptr_d = win_next;
                end
`else
                ptr_d = win_next;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= IDLE;
            ptr           <= '0;
            win           <= '0;
            op_wr         <= 1'b0;
            cnt           <= '0;
            grant         <= '0;
            req_done      <= '0;
            rdata_out     <= '0;
            busy          <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_wdata_oe <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
        end else begin
            state         <= state_d;
            ptr           <= ptr_d;
            win           <= win_d;
            op_wr         <= op_wr_d;
            cnt           <= cnt_d;
            grant         <= grant_d;
            req_done      <= req_done_d;
            rdata_out     <= rdata_d;
            busy          <= busy_d;
            sram_addr     <= addr_d;
            sram_wdata    <= wdata_d;
            sram_wdata_oe <= wdata_oe_d;
            sram_ce_n     <= ce_n_d;
            sram_oe_n     <= oe_n_d;
            sram_we_n     <= we_n_d;
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb/tb_sram_rr_arbiter.sv - self-checking bench for sram_rr_arbiter

module tb_sram_rr_arbiter;

    logic         Clk;
    logic         Reset;
    logic [4:0]   read_req, write_req;
    logic [79:0]  addr_in, wdata_in;
    logic [4:0]   grant, req_done;
    logic [15:0]  rdata_out;
    logic         busy;
    logic [15:0]  sram_addr, sram_wdata, sram_rdata;
    logic         sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n;

    int errors = 0;
    int checks = 0;

    sram_rr_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .read_req(read_req), .write_req(write_req),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .grant(grant), .req_done(req_done), .rdata_out(rdata_out), .busy(busy),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  wr;
        int          req;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] bus;
        logic [4:0]  exp_grant;
        logic        exp_write;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic run_vec(input vec_t v);
        read_req  = v.rd;
        write_req = v.wr;
        addr_in[v.req*16 +: 16]  = v.addr;
        wdata_in[v.req*16 +: 16] = v.wdata;
        sram_rdata = v.bus;
        step();
        chk("setup_grant", grant, v.exp_grant);
        chk("setup_busy", busy, 1);
        chk("setup_ce_n", sram_ce_n, 0);
        chk("setup_we_n", sram_we_n, 1);
        chk("setup_oe_n", sram_oe_n, v.exp_write ? 1 : 0);
        chk("setup_wdata_oe", sram_wdata_oe, v.exp_write ? 1 : 0);
        chk("setup_addr", sram_addr, v.addr);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("access_we_n", sram_we_n, v.exp_write ? 0 : 1);
            chk("access_oe_n", sram_oe_n, v.exp_write ? 1 : 0);
            chk("access_ce_n", sram_ce_n, 0);
            chk("access_addr", sram_addr, v.addr);
            chk("access_req_done", req_done, 0);
            if (v.exp_write) chk("access_wdata", sram_wdata, v.wdata);
        end
        step();
        chk("done_req_done", req_done, v.exp_grant);
        chk("done_grant", grant, v.exp_grant);
        chk("done_rdata", rdata_out, v.exp_rdata);
        chk("done_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 4'b1110);
        read_req  = '0;
        write_req = '0;
        step();
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
        chk("idle_req_done", req_done, 0);
    endtask

    initial begin
        int          ngr;
        int          gtime[6];
        logic [4:0]  gval[6];
        int          dcnt[5];
        logic [4:0]  prev_g;
        logic [4:0]  done_seen;

        vecs[0] = '{5'b00000, 5'b00010, 1, 16'h0040, 16'hBEEF, 16'h0000, 5'b00010, 1'b1, 16'h0000};
        vecs[1] = '{5'b01000, 5'b00000, 3, 16'h0040, 16'h0000, 16'hBEEF, 5'b01000, 1'b0, 16'hBEEF};
        vecs[2] = '{5'b00000, 5'b10000, 4, 16'h1234, 16'hA5A5, 16'h0000, 5'b10000, 1'b1, 16'hBEEF};
        vecs[3] = '{5'b00100, 5'b00100, 2, 16'h0002, 16'h5555, 16'h1111, 5'b00100, 1'b1, 16'hBEEF};
        vecs[4] = '{5'b00001, 5'b00000, 0, 16'hFFFF, 16'h0000, 16'h0F0F, 5'b00001, 1'b0, 16'h0F0F};
        vecs[5] = '{5'b00010, 5'b00000, 1, 16'h0007, 16'h0000, 16'h7777, 5'b00010, 1'b0, 16'h7777};

        Reset = 1'b0; read_req = '0; write_req = '0;
        addr_in = '0; wdata_in = '0; sram_rdata = '0;
        @(negedge Clk);
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_req_done", req_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 4'b1110);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_rdata", rdata_out, 0);
        Reset = 1'b1;
        step();
        chk("idle_no_req", grant, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Pointer is now 2: requesters 0 and 2 arrive together.
        read_req = 5'b00101;
        step();
`ifdef MSTR_PRIORITY_EN
        chk("prio_grant", grant, 5'b00001);
`else
        chk("prio_grant", grant, 5'b00100);
`endif

        // Fairness: every requester reads continuously from reset.
        Reset = 1'b0; read_req = 5'b11111;
        step();
        step();
        Reset = 1'b1;
        ngr = 0; prev_g = '0;
        for (int i = 0; i < 6; i++) begin gtime[i] = 0; gval[i] = '0; end
        for (int i = 0; i < 5; i++) dcnt[i] = 0;
        for (int c = 1; c <= 27; c++) begin
            step();
            if (grant != 0 && prev_g == 0 && ngr < 6) begin
                gval[ngr]  = grant;
                gtime[ngr] = c;
                ngr++;
            end
            prev_g = grant;
            if (c <= 25) for (int b = 0; b < 5; b++) if (req_done[b]) dcnt[b]++;
        end
        chk("fair_ngrants", ngr, 6);
        chk("fair_first_time", gtime[0], 1);
        for (int k = 0; k < 6; k++) begin
`ifdef MSTR_PRIORITY_EN
            chk("fair_order", gval[k], 5'b00001);
`else
            chk("fair_order", gval[k], 5'b00001 << (k % 5));
`endif
            if (k > 0) chk("fair_spacing", gtime[k] - gtime[k-1], 5);
        end
        for (int b = 0; b < 5; b++) begin
`ifdef MSTR_PRIORITY_EN
            chk("fair_done_count", dcnt[b], (b == 0) ? 5 : 0);
`else
            chk("fair_done_count", dcnt[b], 1);
`endif
        end

        // Reset abort during the first ACCESS cycle of a write.
        read_req = '0;
        step();
        step();
        step();
        step();
        step();
        write_req = 5'b00010;
        addr_in[16 +: 16] = 16'h0040;
        wdata_in[16 +: 16] = 16'hBEEF;
        step();
        chk("abort_setup_grant", grant, 5'b00010);
        step();
        chk("abort_access_we_n", sram_we_n, 0);
        Reset = 1'b0;
        step();
        chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 4'b1110);
        chk("abort_grant", grant, 0);
        chk("abort_busy", busy, 0);
        Reset = 1'b1; write_req = '0;
        done_seen = req_done;
        for (int i = 0; i < 3; i++) begin
            step();
            done_seen = done_seen | req_done;
        end
        chk("abort_no_done", done_seen, 0);
        read_req = 5'b10001;
        step();
        chk("abort_ptr0_grant", grant, 5'b00001);
        step();
        step();
        step();
        chk("abort_req0_done", req_done, 5'b00001);
        read_req = 5'b10000;
        step();
        chk("abort_idle_grant", grant, 0);
        step();
        chk("abort_req4_grant", grant, 5'b10000);
        read_req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
